// File: rtl/vpo_ram_control.sv
// vpo_ram_control: video-output ping-pong line buffer.
//   DDR read data (128b words, 8 pixels per word, pixel 0 in [15:0]) is written into
//   one of two line RAMs on i_ddr_clk. The other RAM is read out as 16b pixels on
//   i_pix_clk. A DDR line fetch is requested at frame start and at every line start,
//   so the idle buffer is prefetched with the next line while the current one is shown.
// Ports
//   i_pix_clk, i_ddr_clk : pixel clock / DDR user clock
//   i_rst_n              : async active-low reset, both domains
//   i_soft_rst           : sync soft reset, both domains (same effect as i_rst_n)
//   i_vs, i_de, i_data_en: output timing; a pixel is consumed when i_de && i_data_en
//   o_vs, o_de           : timing delayed 2 pix clocks
//   o_pix_data           : pixel aligned with o_de, 0 when no pixel was consumed
//   o_ddr_req            : 3-cycle fetch request
//   i_ram_wr_*           : DDR-side write port into the buffer selected by wr_sel
//   i_ddr_rd_done        : one-ddr-clk pulse, current line fetch complete
//
// state | meaning
// rd_sel | buffer being displayed (0 at frame start, flips at each line end)
// wr_sel | buffer being filled    (0 at frame start, flips at each fetch done)

// Dual-clock line RAM: 256x128 write port, 2048x16 read port with one cycle latency.
// Read address is {word, lane}; lane 0 is bits [15:0] of the stored word.
module ram_256x128_2048x16_d1_wrap (
  input  logic         i_wr_clk,
  input  logic         i_wr_en,
  input  logic [7:0]   i_wr_addr,
  input  logic [127:0] i_wr_data,
  input  logic         i_rd_clk,
  input  logic [10:0]  i_rd_addr,
  output logic [15:0]  o_rd_data
);
  logic [127:0] mem [256];
  logic [15:0]  rd_data_q;

  always_ff @(posedge i_wr_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_rd_clk) begin
    rd_data_q <= mem[i_rd_addr[10:3]][{i_rd_addr[2:0], 4'b0000} +: 16];
  end

  assign o_rd_data = rd_data_q;
endmodule

module vpo_ram_control #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 27
) (
  input  logic                  i_pix_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ddr_clk,
  input  logic                  i_soft_rst,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic                  i_data_en,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [15:0]           o_pix_data,
  output logic                  o_ddr_req,
  input  logic                  i_ram_wr_en,
  input  logic [7:0]            i_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_wr_data,
  input  logic                  i_ddr_rd_done
);
  // ADDR_WIDTH only exists so the block drops into the system with the common
  // parameter set; the line buffer itself never sees a DDR address.
  if (ADDR_WIDTH < 1) begin : g_addr_width_unused
  end

  // ---------------- pixel clock domain ----------------
  logic        vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
  logic        de_d1_q, de_d1_d, de_d2_q, de_d2_d;
  logic        take_d1_q, take_d1_d;
  logic        evt_q, evt_d, evt_d1_q, evt_d1_d, evt_d2_q, evt_d2_d;
  logic        ddr_req_q, ddr_req_d;
  logic        rd_sel_q, rd_sel_d, rd_sel_d1_q, rd_sel_d1_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [15:0] pix_q, pix_d;
  logic        pos_vs, pos_de, neg_de, pix_take;
  logic [15:0] ram0_rd, ram1_rd;

  always_comb begin
    pos_vs   = vs_d1_q & ~vs_d2_q;
    pos_de   = de_d1_q & ~de_d2_q;
    neg_de   = ~de_d1_q & de_d2_q;
    pix_take = i_de & i_data_en;

    vs_d1_d   = i_vs;
    vs_d2_d   = vs_d1_q;
    de_d1_d   = i_de;
    de_d2_d   = de_d1_q;
    take_d1_d = pix_take;

    // Events closer than 3 cycles simply merge into one longer request.
    evt_d     = pos_vs | pos_de;
    evt_d1_d  = evt_q;
    evt_d2_d  = evt_d1_q;
    ddr_req_d = evt_q | evt_d1_q | evt_d2_q;

    rd_sel_d = rd_sel_q;
    if (pos_vs)      rd_sel_d = 1'b0;
    else if (neg_de) rd_sel_d = ~rd_sel_q;

    // Wraps silently at 2047; longer lines are not supported.
    rd_addr_d = rd_addr_q;
    if (pos_vs || neg_de) rd_addr_d = '0;
    else if (pix_take)    rd_addr_d = rd_addr_q + 11'd1;

    // The RAM output lags its address by one cycle, so the buffer select and the
    // pixel qualifier are delayed once to line up with it.
    rd_sel_d1_d = rd_sel_q;
    pix_d       = take_d1_q ? (rd_sel_d1_q ? ram1_rd : ram0_rd) : 16'h0000;

    if (i_soft_rst) begin
      vs_d1_d     = 1'b0;
      vs_d2_d     = 1'b0;
      de_d1_d     = 1'b0;
      de_d2_d     = 1'b0;
      take_d1_d   = 1'b0;
      evt_d       = 1'b0;
      evt_d1_d    = 1'b0;
      evt_d2_d    = 1'b0;
      ddr_req_d   = 1'b0;
      rd_sel_d    = 1'b0;
      rd_sel_d1_d = 1'b0;
      rd_addr_d   = '0;
      pix_d       = 16'h0000;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_d1_q     <= 1'b0;
      vs_d2_q     <= 1'b0;
      de_d1_q     <= 1'b0;
      de_d2_q     <= 1'b0;
      take_d1_q   <= 1'b0;
      evt_q       <= 1'b0;
      evt_d1_q    <= 1'b0;
      evt_d2_q    <= 1'b0;
      ddr_req_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_sel_d1_q <= 1'b0;
      rd_addr_q   <= '0;
      pix_q       <= 16'h0000;
    end else begin
      vs_d1_q     <= vs_d1_d;
      vs_d2_q     <= vs_d2_d;
      de_d1_q     <= de_d1_d;
      de_d2_q     <= de_d2_d;
      take_d1_q   <= take_d1_d;
      evt_q       <= evt_d;
      evt_d1_q    <= evt_d1_d;
      evt_d2_q    <= evt_d2_d;
      ddr_req_q   <= ddr_req_d;
      rd_sel_q    <= rd_sel_d;
      rd_sel_d1_q <= rd_sel_d1_d;
      rd_addr_q   <= rd_addr_d;
      pix_q       <= pix_d;
    end
  end

  assign o_vs       = vs_d2_q;
  assign o_de       = de_d2_q;
  assign o_ddr_req  = ddr_req_q;
  assign o_pix_data = pix_q;

  // ---------------- DDR clock domain ----------------
  // i_vs is brought across with two flops; a third flop gives the edge detect.
  // i_soft_rst is used directly and is expected to be held at least one ddr clock.
  logic vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
  logic wr_sel_q, wr_sel_d;
  logic wr_vs_rise;
  logic wr_en0, wr_en1;

  always_comb begin
    wr_vs_rise = vs_s2_q & ~vs_s3_q;
    vs_s1_d    = i_vs;
    vs_s2_d    = vs_s1_q;
    vs_s3_d    = vs_s2_q;

    wr_sel_d = wr_sel_q;
    if (wr_vs_rise)         wr_sel_d = 1'b0;
    else if (i_ddr_rd_done) wr_sel_d = ~wr_sel_q;

    if (i_soft_rst) begin
      vs_s1_d  = 1'b0;
      vs_s2_d  = 1'b0;
      vs_s3_d  = 1'b0;
      wr_sel_d = 1'b0;
    end
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      wr_sel_q <= 1'b0;
    end else begin
      vs_s1_q  <= vs_s1_d;
      vs_s2_q  <= vs_s2_d;
      vs_s3_q  <= vs_s3_d;
      wr_sel_q <= wr_sel_d;
    end
  end

  assign wr_en0 = i_ram_wr_en & ~wr_sel_q;
  assign wr_en1 = i_ram_wr_en &  wr_sel_q;

  ram_256x128_2048x16_d1_wrap u_ram0 (
    .i_wr_clk  (i_ddr_clk),
    .i_wr_en   (wr_en0),
    .i_wr_addr (i_ram_wr_addr),
    .i_wr_data (i_ram_wr_data),
    .i_rd_clk  (i_pix_clk),
    .i_rd_addr (rd_addr_q),
    .o_rd_data (ram0_rd)
  );

  ram_256x128_2048x16_d1_wrap u_ram1 (
    .i_wr_clk  (i_ddr_clk),
    .i_wr_en   (wr_en1),
    .i_wr_addr (i_ram_wr_addr),
    .i_wr_data (i_ram_wr_data),
    .i_rd_clk  (i_pix_clk),
    .i_rd_addr (rd_addr_q),
    .o_rd_data (ram1_rd)
  );
endmodule

// File: tb/tb_vpo_ram_control.sv
// tb_vpo_ram_control: directed bench for vpo_ram_control.
//   Inputs are driven on the falling pixel clock edge, outputs sampled on the same
//   falling edge before the next drive. Line data written into the buffers is
//   {tag[3:0], pixel_index[11:0]}, so every pixel identifies its line and position.
module tb_vpo_ram_control;
  localparam int DW = 128;

  logic          i_pix_clk = 1'b0;
  logic          i_ddr_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_soft_rst = 1'b0;
  logic          i_vs = 1'b0;
  logic          i_de = 1'b0;
  logic          i_data_en = 1'b0;
  logic          i_ram_wr_en = 1'b0;
  logic [7:0]    i_ram_wr_addr = 8'h00;
  logic [DW-1:0] i_ram_wr_data = '0;
  logic          i_ddr_rd_done = 1'b0;
  logic          o_vs, o_de, o_ddr_req;
  logic [15:0]   o_pix_data;

  always #5 i_pix_clk = ~i_pix_clk;
  always #3 i_ddr_clk = ~i_ddr_clk;

  vpo_ram_control #(.DATA_WIDTH(DW), .ADDR_WIDTH(27)) dut (
    .i_pix_clk     (i_pix_clk),
    .i_rst_n       (i_rst_n),
    .i_ddr_clk     (i_ddr_clk),
    .i_soft_rst    (i_soft_rst),
    .i_vs          (i_vs),
    .i_de          (i_de),
    .i_data_en     (i_data_en),
    .o_vs          (o_vs),
    .o_de          (o_de),
    .o_pix_data    (o_pix_data),
    .o_ddr_req     (o_ddr_req),
    .i_ram_wr_en   (i_ram_wr_en),
    .i_ram_wr_addr (i_ram_wr_addr),
    .i_ram_wr_data (i_ram_wr_data),
    .i_ddr_rd_done (i_ddr_rd_done)
  );

  int errors = 0;
  int checks = 0;

  // Expected-output model: inputs of the two previous cycles, recent request events,
  // and which line tag each buffer currently holds.
  logic        h1_vs = 0, h1_de = 0, h2_vs = 0, h2_de = 0;
  logic [15:0] h1_pix = 0, h2_pix = 0;
  logic [5:0]  evt_hist = 0;
  logic        prev_vs = 0, prev_de = 0;
  int          rd_buf = 0, rd_idx = 0, wr_buf = 0;
  logic [3:0]  buf_tag [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic vs, input logic de, input logic en, input logic srst);
    logic evt;
    logic [15:0] pix;
    @(negedge i_pix_clk);
    chk("o_vs", {15'd0, o_vs}, {15'd0, h2_vs});
    chk("o_de", {15'd0, o_de}, {15'd0, h2_de});
    chk("o_pix_data", o_pix_data, h2_pix);
    chk("o_ddr_req", {15'd0, o_ddr_req}, {15'd0, |evt_hist[4:2]});

    if (vs && !prev_vs) begin
      rd_buf = 0;
      rd_idx = 0;
      wr_buf = 0;
    end
    if (!de && prev_de) begin
      rd_buf = 1 - rd_buf;
      rd_idx = 0;
    end
    evt = (vs & ~prev_vs) | (de & ~prev_de);
    pix = 16'h0000;
    if (de && en) begin
      pix = {buf_tag[rd_buf], rd_idx[11:0]};
      rd_idx++;
    end
    h2_vs = h1_vs; h2_de = h1_de; h2_pix = h1_pix;
    h1_vs = vs;    h1_de = de;    h1_pix = pix;
    evt_hist = {evt_hist[4:0], evt};
    prev_vs = vs;
    prev_de = de;
    if (srst || !i_rst_n) begin
      h1_vs = 0; h1_de = 0; h1_pix = 0;
      h2_vs = 0; h2_de = 0; h2_pix = 0;
      evt_hist = 0;
      prev_vs = 0; prev_de = 0;
      rd_buf = 0; rd_idx = 0; wr_buf = 0;
    end

    i_vs = vs;
    i_de = de;
    i_data_en = en;
    i_soft_rst = srst;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int c = 0; c < n; c++) step(vs, 1'b0, 1'b0, 1'b0);
  endtask

  // Active line of ncyc de-cycles followed by 40 blanking cycles.
  task automatic line(input int ncyc, input bit alt);
    for (int c = 0; c < ncyc; c++) step(1'b0, 1'b1, alt ? (c % 2 == 0) : 1'b1, 1'b0);
    idle(40, 1'b0);
  endtask

  task automatic frame_start();
    idle(4, 1'b1);
    idle(4, 1'b0);
  endtask

  // Writes 240 words of line data with the given tag; the done pulse follows either
  // at once or shortly after i_de falls, so it lands close to the line-end toggle.
  task automatic write_line(input logic [3:0] tag, input bit wait_de_fall);
    int b;
    repeat (10) @(negedge i_ddr_clk);
    b = wr_buf;
    for (int w = 0; w < 240; w++) begin
      @(negedge i_ddr_clk);
      i_ram_wr_en = 1'b1;
      i_ram_wr_addr = w[7:0];
      for (int l = 0; l < 8; l++) i_ram_wr_data[l*16 +: 16] = {tag, 12'(w * 8 + l)};
    end
    @(negedge i_ddr_clk);
    i_ram_wr_en = 1'b0;
    buf_tag[b] = tag;
    if (wait_de_fall) begin
      for (int c = 0; c < 20000 && i_de; c++) @(negedge i_ddr_clk);
      repeat (3) @(negedge i_ddr_clk);
    end
    @(negedge i_ddr_clk);
    i_ddr_rd_done = 1'b1;
    @(negedge i_ddr_clk);
    i_ddr_rd_done = 1'b0;
    wr_buf = 1 - wr_buf;
  endtask

  initial begin
    buf_tag[0] = 4'h0;
    buf_tag[1] = 4'h0;

    // Reset held while timing inputs toggle: everything stays 0.
    for (int c = 0; c < 10; c++) step(c[0], c[1], 1'b1, 1'b0);
    idle(3, 1'b0);
    i_rst_n = 1'b1;
    idle(6, 1'b0);

    // Frame 1: request on vs rise, then fill buffer 0 with line tag 1.
    frame_start();
    fork
      write_line(4'h1, 1'b0);
      idle(200, 1'b0);
    join

    // Three lines; each one prefetches the next into the idle buffer.
    fork
      line(1920, 1'b0);
      write_line(4'h2, 1'b1);
    join
    fork
      line(3840, 1'b1);
      write_line(4'h3, 1'b1);
    join
    line(1920, 1'b0);

    // Frame 2: fresh fill of buffer 0, soft reset after 500 pixels.
    frame_start();
    fork
      write_line(4'h5, 1'b0);
      idle(200, 1'b0);
    join
    for (int c = 0; c < 500; c++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(20, 1'b0);

    // Frame 3: readout restarts from pixel 0 of buffer 0.
    frame_start();
    idle(20, 1'b0);
    line(600, 1'b0);
    idle(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
